byte_striping_tx_param: RTL and testbench

Parametrised transmit byte-striper for the multi-lane link, successor to the fixed 4-lane stripe stage on the PHY side of the transmit path. It accepts one DATA_W-bit word per valid cycle and distributes consecutive words round-robin across a runtime-selectable number of lanes. Each complete lane group is presented as one registered, aligned output word with a single-cycle strobe. A flush request closes a partial group by padding the unused lanes, and a lane mask reports which lanes carry real data.

---
 rtl/bs_pkg.sv | 22 ++
 rtl/bs_lane_ptr.sv | 28 ++
 rtl/byte_striping_tx_param.sv | 112 +++++++++++
 tb/tb_byte_striping_tx_param.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bs_pkg.sv
// Shared constants for the parametrised transmit byte-striper: lane-count
// encodings, FSM state codes and the default pad value.
package bs_pkg;

    localparam int unsigned BS_CFG_1L  = 0;
    localparam int unsigned BS_CFG_2L  = 1;
    localparam int unsigned BS_CFG_4L  = 2;
    localparam int unsigned BS_CFG_8L  = 3;
    localparam int unsigned BS_CFG_16L = 4;

    localparam logic [0:0] BS_IDLE = 1'b0;
    localparam logic [0:0] BS_FILL = 1'b1;

    // Empty lanes are filled by replicating this bit across DATA_W.
    localparam logic BS_PAD_BIT = 1'b0;

    // Active lane count for a log2 config, saturated at the physical count.
    function automatic int unsigned bs_active_lanes(int unsigned cfg, int unsigned max_log2);
        return (cfg > max_log2) ? (1 << max_log2) : (1 << cfg);
    endfunction

endpackage

// File: rtl/bs_lane_ptr.sv
// Lane pointer with programmable modulus n; last flags the final slot of a group.
module bs_lane_ptr #(
    parameter int LANES = 4,
    parameter int PW    = (LANES > 1) ? $clog2(LANES) : 1,
    parameter int NW    = $clog2(LANES) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          clr,
    input  logic [NW-1:0] n,
    output logic [PW-1:0] ptr,
    output logic          last
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PW'(1);
        end
    end

    assign last = (NW'(ptr) == (n - NW'(1)));

endmodule

// File: rtl/byte_striping_tx_param.sv
// Round-robin byte-striper: stages words into lane slots and emits each
// complete (or flushed) group as one registered word with a one-cycle strobe.
module byte_striping_tx_param
    import bs_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter int                LANES  = 4,
    parameter logic [DATA_W-1:0] PAD    = {DATA_W{BS_PAD_BIT}}
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid,
    input  logic [DATA_W-1:0]         data,
    input  logic                      flush,
    input  logic [$clog2(LANES):0]    lanes_cfg,
    output logic [LANES*DATA_W-1:0]   data_out,
    output logic                      word_valid,
    output logic [LANES-1:0]          lane_mask,
    output logic                      busy,
    output logic [0:0]                dbg_state
);

    localparam int CW    = $clog2(LANES) + 1;
    localparam int PW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int LOG2L = $clog2(LANES);

    // Handshake: a word is taken on every cycle valid is high; there is no
    // ready. word_valid is a single-cycle strobe and data_out/lane_mask are
    // stable from that cycle until the next strobe.

    logic [0:0]               state;
    logic [CW-1:0]            n_q;
    logic [CW-1:0]            cfg_n;
    logic [CW-1:0]            n_eff;
    logic [PW-1:0]            ptr;
    logic                     last;
    logic                     emit;
    logic [DATA_W-1:0]        stage [LANES];
    logic [LANES*DATA_W-1:0]  grp_data;
    logic [LANES-1:0]         grp_mask;

    always_comb begin
        if (lanes_cfg > CW'(LOG2L)) begin
            cfg_n = CW'(LANES);
        end else begin
            cfg_n = CW'(1) << lanes_cfg;
        end
    end

    // The group size is taken live while idle and frozen once a group opens.
    assign n_eff = (state == BS_IDLE) ? cfg_n : n_q;
    assign emit  = (valid && last) || (flush && (state == BS_FILL));

    bs_lane_ptr #(.LANES(LANES), .PW(PW), .NW(CW)) u_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (valid && !emit),
        .clr   (emit),
        .n     (n_eff),
        .ptr   (ptr),
        .last  (last)
    );

    // Slots below ptr are staged, slot ptr takes the incoming word, rest pad.
    always_comb begin
        grp_data = '0;
        grp_mask = '0;
        for (int k = 0; k < LANES; k++) begin
            if (k < int'(ptr)) begin
                grp_data[k*DATA_W +: DATA_W] = stage[k];
                grp_mask[k]                  = 1'b1;
            end else if ((k == int'(ptr)) && valid) begin
                grp_data[k*DATA_W +: DATA_W] = data;
                grp_mask[k]                  = 1'b1;
            end else begin
                grp_data[k*DATA_W +: DATA_W] = PAD;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= BS_IDLE;
            n_q        <= CW'(1);
            data_out   <= '0;
            lane_mask  <= '0;
            word_valid <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                stage[k] <= '0;
            end
        end else begin
            word_valid <= emit;
            if (state == BS_IDLE && valid) begin
                n_q <= cfg_n;
            end
            if (valid && !emit) begin
                stage[ptr] <= data;
            end
            if (emit) begin
                data_out  <= grp_data;
                lane_mask <= grp_mask;
                state     <= BS_IDLE;
            end else if (valid) begin
                state     <= BS_FILL;
            end
        end
    end

    assign busy      = (state == BS_FILL);
    assign dbg_state = state;

endmodule

// File: tb/tb_byte_striping_tx_param.sv
// Directed plus random bench for byte_striping_tx_param (DATA_W=8, LANES=4)
// against a queue-based group model.
module tb_byte_striping_tx_param;

    localparam int DATA_W = 8;
    localparam int LANES  = 4;

    logic                     clk;
    logic                     reset;
    logic                     valid;
    logic [DATA_W-1:0]        data;
    logic                     flush;
    logic [2:0]               lanes_cfg;
    logic [LANES*DATA_W-1:0]  data_out;
    logic                     word_valid;
    logic [LANES-1:0]         lane_mask;
    logic                     busy;
    logic [0:0]               dbg_state;

    int total = 0;
    int bad   = 0;

    // model state
    logic [DATA_W-1:0]       stg_q[$];
    int                      n_act = 1;
    logic [LANES*DATA_W-1:0] exp_data = '0;
    logic [LANES-1:0]        exp_mask = '0;
    logic                    exp_wv   = 1'b0;
    logic                    exp_busy = 1'b0;

    byte_striping_tx_param #(.DATA_W(DATA_W), .LANES(LANES)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid      (valid),
        .data       (data),
        .flush      (flush),
        .lanes_cfg  (lanes_cfg),
        .data_out   (data_out),
        .word_valid (word_valid),
        .lane_mask  (lane_mask),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".word_valid"}, 64'(word_valid), 64'(exp_wv));
        check({tag, ".busy"},       64'(busy),       64'(exp_busy));
        check({tag, ".state"},      64'(dbg_state),  64'(exp_busy));
        check({tag, ".data_out"},   64'(data_out),   64'(exp_data));
        check({tag, ".lane_mask"},  64'(lane_mask),  64'(exp_mask));
    endtask

    // One clock: drive inputs, advance the model, check after the edge.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic f,
                        input logic [2:0] cfg, input string tag);
        int pre;
        int c;
        @(negedge clk);
        valid     = v;
        data      = d;
        flush     = f;
        lanes_cfg = cfg;
        pre = stg_q.size();
        if (pre == 0 && v) begin
            c = (int'(cfg) > 2) ? 2 : int'(cfg);
            n_act = 1 << c;
        end
        if (v) stg_q.push_back(d);
        exp_wv = 1'b0;
        if ((v && (pre + 1 == n_act)) || (f && pre > 0)) begin
            exp_wv   = 1'b1;
            exp_data = '0;
            exp_mask = '0;
            for (int k = 0; k < LANES; k++) begin
                if (k < stg_q.size()) begin
                    exp_data[k*DATA_W +: DATA_W] = stg_q[k];
                    exp_mask[k] = 1'b1;
                end
            end
            stg_q.delete();
        end
        exp_busy = (stg_q.size() > 0);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        valid = 1'b0;
        flush = 1'b0;
        reset = 1'b0;
        #1;
        stg_q.delete();
        exp_data = '0;
        exp_mask = '0;
        exp_wv   = 1'b0;
        exp_busy = 1'b0;
        check_all(tag);
        repeat (2) @(posedge clk);
        #1;
        check_all({tag, ".held"});
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        valid     = 1'b0;
        data      = '0;
        flush     = 1'b0;
        lanes_cfg = 3'd2;
        #1;
        check_all("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // four lanes, two full groups back to back
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 3'd2, "full4");
        check("full4.last_data", 64'(data_out), 64'h08070605);

        // two lanes, upper lanes padded
        step(1'b1, 8'hAA, 1'b0, 3'd1, "two.a");
        step(1'b1, 8'hBB, 1'b0, 3'd1, "two.b");
        check("two.data", 64'(data_out), 64'h0000BBAA);
        check("two.mask", 64'(lane_mask), 64'h3);

        // flush a partial group, then flush again while idle
        step(1'b1, 8'h11, 1'b0, 3'd2, "fl.a");
        step(1'b1, 8'h22, 1'b0, 3'd2, "fl.b");
        step(1'b0, 8'h00, 1'b1, 3'd2, "fl.flush");
        check("fl.data", 64'(data_out), 64'h00002211);
        step(1'b0, 8'h00, 1'b1, 3'd2, "fl.idle");
        step(1'b0, 8'h00, 1'b0, 3'd2, "fl.quiet");

        // word and flush in the same cycle
        step(1'b1, 8'h11, 1'b0, 3'd2, "vf.a");
        step(1'b1, 8'h22, 1'b1, 3'd2, "vf.b");
        check("vf.mask", 64'(lane_mask), 64'h3);
        step(1'b0, 8'h00, 1'b0, 3'd2, "vf.after");

        // config change mid-group is ignored until the next group
        step(1'b1, 8'h31, 1'b0, 3'd2, "cfg.a");
        step(1'b1, 8'h32, 1'b0, 3'd2, "cfg.b");
        step(1'b1, 8'h33, 1'b0, 3'd0, "cfg.c");
        step(1'b1, 8'h34, 1'b0, 3'd0, "cfg.d");
        check("cfg.grp", 64'(data_out), 64'h34333231);
        step(1'b1, 8'h35, 1'b0, 3'd0, "cfg.n1a");
        step(1'b1, 8'h36, 1'b0, 3'd0, "cfg.n1b");
        check("cfg.n1", 64'(data_out), 64'h00000036);

        // reset mid-group discards staged words
        step(1'b1, 8'h01, 1'b0, 3'd2, "rst.a");
        step(1'b1, 8'h02, 1'b0, 3'd2, "rst.b");
        step(1'b1, 8'h03, 1'b0, 3'd2, "rst.c");
        do_reset("rst.mid");
        for (int i = 5; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 3'd2, "rst.post");
        check("rst.grp", 64'(data_out), 64'h08070605);

        // randomized traffic, including saturating configs and resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rnd.reset");
            end else begin
                step(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                     ($urandom_range(0, 9) == 0), 3'($urandom_range(0, 4)), "rnd");
            end
        end

        step(1'b0, 8'h00, 1'b0, 3'd2, "tail");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
